// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the single Common Data Bus (CDB) between the functional-unit
//   requesters (ALU reservation station, load unit, branch unit, ...).
//   Each cycle one requester is granted combinationally using a round-robin
//   pointer; on the following clock edge the winner's ROB tag and result are
//   registered onto the CDB for reservation-station wakeup and ROB writeback.
//   Requester 0 is the ALU reservation station and takes its cdb_grant from
//   grant[0].
//
// Optional feature (compile-time macro CDB_STARVE_EN):
//   Defined     - every requester has a saturating wait counter; a requester
//                 whose counter reaches MAX_WAIT is flagged in 'starved' and
//                 the lowest-index starved requester overrides round-robin.
//   Not defined - pure round-robin, 'starved' tied to zero.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   TAG_W     ROB tag width
//   DATA_W    result width
//   MAX_WAIT  starvation threshold in cycles (only with CDB_STARVE_EN)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   mispredict  flush: drop all in-flight broadcasts, clear wait counters
//   bus_en      CDB may accept a new broadcast this cycle
//   req         requester i holds a result ready for broadcast
//   req_tag     ROB tag of requester i in slice [i*TAG_W +: TAG_W]
//   req_data    result of requester i in slice [i*DATA_W +: DATA_W]
//   grant       one-hot combinational grant, same cycle as req
//   cdb_valid   registered broadcast valid
//   cdb_tag     registered broadcast tag
//   cdb_data    registered broadcast data
//   starved     requester i is at MAX_WAIT (zero when feature compiled out)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NREQ     = 4,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mispredict,
  input  logic                     bus_en,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          grant,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [NREQ-1:0]          starved
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Reject configurations the pointer arithmetic and counters are not sized for.
  if (NREQ < 2 || NREQ > 8 || MAX_WAIT < 1) begin : gBadParams
    $error("cdb_arbiter: unsupported parameter values");
  end

  logic [PTR_W-1:0]  r_rrPtr;
  logic              r_cdbValid;
  logic [TAG_W-1:0]  r_cdbTag;
  logic [DATA_W-1:0] r_cdbData;

  logic              w_rrFound;
  logic [PTR_W-1:0]  w_rrIdx;
  logic              w_selFound;
  logic [PTR_W-1:0]  w_selIdx;
  logic              w_grantEn;
  logic              w_winValid;

  // Grants are suppressed while in reset, while the bus is busy, and on a flush.
  assign w_grantEn = rst & bus_en & ~mispredict;

  // Round-robin scan: first set request at or above the pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    w_rrFound = 1'b0;
    w_rrIdx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rrPtr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!w_rrFound && req[idx]) begin
        w_rrFound = 1'b1;
        w_rrIdx   = PTR_W'(idx);
      end
    end
  end

`ifdef CDB_STARVE_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_waitCnt [NREQ];
  logic [NREQ-1:0]  w_starved;
  logic             w_stFound;
  logic [PTR_W-1:0] w_stIdx;

  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_starved[i] = (r_waitCnt[i] == CNT_W'(MAX_WAIT));
    end
  end

  // A starved requester only wins while it is still requesting, so a grant
  // never lands on an idle requester.
  always_comb begin
    w_stFound = 1'b0;
    w_stIdx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_stFound && w_starved[i] && req[i]) begin
        w_stFound = 1'b1;
        w_stIdx   = PTR_W'(i);
      end
    end
  end

  assign w_selFound = w_stFound | w_rrFound;
  assign w_selIdx   = w_stFound ? w_stIdx : w_rrIdx;
  assign starved    = w_starved;

  // Counters advance on every losing edge (including bus_en=0 edges) and
  // saturate; a flush wipes all waiting history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_waitCnt[i] <= '0;
      end
    end else if (mispredict) begin
      for (int i = 0; i < NREQ; i++) begin
        r_waitCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !grant[i]) begin
          if (r_waitCnt[i] != CNT_W'(MAX_WAIT)) begin
            r_waitCnt[i] <= r_waitCnt[i] + 1'b1;
          end
        end else begin
          r_waitCnt[i] <= '0;
        end
      end
    end
  end
`else
  assign w_selFound = w_rrFound;
  assign w_selIdx   = w_rrIdx;
  assign starved    = '0;
`endif

  // One-hot grant decode from the selected winner.
  always_comb begin
    grant      = '0;
    w_winValid = 1'b0;
    if (w_grantEn && w_selFound) begin
      grant[w_selIdx] = 1'b1;
      w_winValid      = 1'b1;
    end
  end

  // Broadcast register and round-robin pointer. Tag and data hold when idle
  // so consumers see stable values even with cdb_valid low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cdbValid <= 1'b0;
      r_cdbTag   <= '0;
      r_cdbData  <= '0;
      r_rrPtr    <= '0;
    end else if (w_winValid) begin
      r_cdbValid <= 1'b1;
      r_cdbTag   <= req_tag[w_selIdx*TAG_W +: TAG_W];
      r_cdbData  <= req_data[w_selIdx*DATA_W +: DATA_W];
      r_rrPtr    <= (w_selIdx == PTR_W'(NREQ - 1)) ? '0 : w_selIdx + 1'b1;
    end else begin
      r_cdbValid <= 1'b0;
    end
  end

  assign cdb_valid = r_cdbValid;
  assign cdb_tag   = r_cdbTag;
  assign cdb_data  = r_cdbData;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter with NREQ=4, TAG_W=4, DATA_W=32, MAX_WAIT=7.
// Inputs change on the falling edge; grant is sampled 1 time unit later and
// the registered CDB outputs 1 time unit after the rising edge. Expected
// starvation results depend on whether CDB_STARVE_EN is defined.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        mispredict;
  logic        bus_en;
  logic [3:0]  req;
  logic [15:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  grant;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  starved;

  int checks;
  int failures;

  cdb_arbiter #(
    .NREQ(4),
    .TAG_W(4),
    .DATA_W(32),
    .MAX_WAIT(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mispredict(mispredict),
    .bus_en(bus_en),
    .req(req),
    .req_tag(req_tag),
    .req_data(req_data),
    .grant(grant),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .starved(starved)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts, asserts, reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic be, input logic mp);
    req        = r;
    bus_en     = be;
    mispredict = mp;
  endtask

  task automatic setPayload(input int idx, input logic [3:0] t, input logic [31:0] d);
    req_tag[idx*4 +: 4]   = t;
    req_data[idx*32 +: 32] = d;
  endtask

  // One full cycle: drive on the falling edge, check grant, then check the
  // registered broadcast just after the rising edge.
  task automatic runCycle(input string name, input logic [3:0] r, input logic be,
                          input logic mp, input logic [3:0] expGrant,
                          input logic expValid, input logic [3:0] expTag,
                          input logic [31:0] expData);
    @(negedge clk);
    applyStimulus(r, be, mp);
    #1;
    checkOutput({name, "_grant"}, 64'(grant), 64'(expGrant));
    @(posedge clk);
    #1;
    checkOutput({name, "_valid"}, 64'(cdb_valid), 64'(expValid));
    checkOutput({name, "_tag"}, 64'(cdb_tag), 64'(expTag));
    checkOutput({name, "_data"}, 64'(cdb_data), 64'(expData));
  endtask

  initial begin
    logic [3:0]  expStarved;
    logic [3:0]  expGrant;
    logic [3:0]  expTag;
    logic [31:0] expData;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req        = '0;
    req_tag    = '0;
    req_data   = '0;
    bus_en     = 1'b1;
    mispredict = 1'b0;

    // Reset asserted: everything zero and grant suppressed even with requests.
    #1 rst = 1'b0;
    #1 applyStimulus(4'b1111, 1'b1, 1'b0);
    #1;
    checkOutput("reset_grant", 64'(grant), 64'h0);
    checkOutput("reset_valid", 64'(cdb_valid), 64'h0);
    checkOutput("reset_tag", 64'(cdb_tag), 64'h0);
    checkOutput("reset_data", 64'(cdb_data), 64'h0);
    checkOutput("reset_starved", 64'(starved), 64'h0);

    // Single requester 1: same-cycle grant, broadcast on the next cycle.
    @(negedge clk);
    rst = 1'b1;
    setPayload(1, 4'd5, 32'hDEAD_BEEF);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    #1;
    checkOutput("single_grant", 64'(grant), 64'b0010);
    @(posedge clk);
    #1;
    checkOutput("single_valid", 64'(cdb_valid), 64'h1);
    checkOutput("single_tag", 64'(cdb_tag), 64'h5);
    checkOutput("single_data", 64'(cdb_data), 64'hDEAD_BEEF);

    // Asynchronous reset mid-broadcast clears outputs before the next edge.
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(cdb_valid), 64'h0);
    checkOutput("async_rst_tag", 64'(cdb_tag), 64'h0);
    checkOutput("async_rst_data", 64'(cdb_data), 64'h0);
    checkOutput("async_rst_grant", 64'(grant), 64'h0);

    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      setPayload(i, 4'(8 + i), 32'hA000_0000 + 32'(i));
    end

    // Round-robin from pointer 0 with all four requesting for 8 cycles.
    for (int k = 0; k < 8; k++) begin
      runCycle("rr", 4'b1111, 1'b1, 1'b0, 4'(1 << (k % 4)), 1'b1,
               4'(8 + (k % 4)), 32'hA000_0000 + 32'(k % 4));
    end

    // Wrap: move pointer to 3, then 3 wins and wraps to 0, then 0 wins.
    runCycle("wrap_setup", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 4'd10, 32'hA000_0002);
    runCycle("wrap_hi", 4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 4'd11, 32'hA000_0003);
    runCycle("wrap_lo", 4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1, 4'd8, 32'hA000_0000);

    // Flush: no grant, valid drops, tag/data hold, pointer still at 1.
    runCycle("flush", 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 4'd8, 32'hA000_0000);
    runCycle("post_flush", 4'b0110, 1'b1, 1'b0, 4'b0010, 1'b1, 4'd9, 32'hA000_0001);

    // Bus busy and empty request both look idle.
    runCycle("bus_off", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd9, 32'hA000_0001);
    runCycle("no_req", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd9, 32'hA000_0001);

    // A lone continuous requester is granted every cycle.
    for (int k = 0; k < 3; k++) begin
      runCycle("cont", 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 4'd8, 32'hA000_0000);
    end
    runCycle("ptr_to_0", 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'd11, 32'hA000_0003);

    // Starvation: requester 3 loses 7 edges while the bus is busy.
    for (int j = 1; j <= 7; j++) begin
      runCycle("starve_wait", 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd11, 32'hA000_0003);
`ifdef CDB_STARVE_EN
      expStarved = (j >= 7) ? 4'b1000 : 4'b0000;
`else
      expStarved = 4'b0000;
`endif
      checkOutput("starve_flag", 64'(starved), 64'(expStarved));
    end

`ifdef CDB_STARVE_EN
    expGrant = 4'b1000;
    expTag   = 4'd11;
    expData  = 32'hA000_0003;
`else
    expGrant = 4'b0001;
    expTag   = 4'd8;
    expData  = 32'hA000_0000;
`endif
    runCycle("starve_win", 4'b1001, 1'b1, 1'b0, expGrant, 1'b1, expTag, expData);
    checkOutput("starve_cleared", 64'(starved), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
